// File: rtl/sdram_cmd_responder.sv
// sdram_cmd_responder
//   Device-side model of an SDRAM command bus. Decodes CS_n/RAS_n/CAS_n/WE_n,
//   tracks the single-row device state, enforces tRCD/tRP/tRC/tMRD/tWR, flags
//   protocol violations, and backs READ/WRITE with a small internal array.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   cs_n..we_n        command strobes (active low)
//   ba                bank address, latched with ACT (informational only)
//   addr              row (ACT), column + A10 auto-precharge (READ/WRITE), mode (MRS)
//   dqm               write mask, 1 suppresses the array write
//   dq_in             write data, sampled in the WRITE cycle
//   dq_out, dq_oe     read data and its one-cycle valid, CL cycles after READ
//   state_out         current state code (controller encoding)
//   cmd_err           one-cycle violation pulse
//   err_code          cause of the last violation (1 stable, 2 timed, 3 bad CL)
module sdram_cmd_responder #(
    parameter int DQ_W     = 16,
    parameter int ADDR_W   = 12,
    parameter int COL_W    = 8,
    parameter int MEM_AW   = 8,
    parameter int T_RCD    = 2,
    parameter int T_RP     = 2,
    parameter int T_RC     = 6,
    parameter int T_MRD    = 2,
    parameter int T_WR     = 2,
    parameter int CL_RESET = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              ras_n,
    input  logic              cas_n,
    input  logic              we_n,
    input  logic [1:0]        ba,
    input  logic [ADDR_W-1:0] addr,
    input  logic              dqm,
    input  logic [DQ_W-1:0]   dq_in,
    output logic [DQ_W-1:0]   dq_out,
    output logic              dq_oe,
    output logic [3:0]        state_out,
    output logic              cmd_err,
    output logic [2:0]        err_code
);

    localparam logic [3:0] S_IDLE  = 4'h0;
    localparam logic [3:0] S_ROWA  = 4'h1;
    localparam logic [3:0] S_PRE   = 4'h6;
    localparam logic [3:0] S_ROWNG = 4'h7;
    localparam logic [3:0] S_WREC  = 4'h8;
    localparam logic [3:0] S_WRECA = 4'h9;
    localparam logic [3:0] S_AUTO  = 4'hA;
    localparam logic [3:0] S_MRS   = 4'hB;

    localparam logic [2:0] C_NOP   = 3'd0;
    localparam logic [2:0] C_ACT   = 3'd1;
    localparam logic [2:0] C_READ  = 3'd2;
    localparam logic [2:0] C_WRITE = 3'd3;
    localparam logic [2:0] C_PRE   = 3'd4;
    localparam logic [2:0] C_REF   = 3'd5;
    localparam logic [2:0] C_MRS   = 3'd6;

    localparam int CNT_W = 4;

    logic [3:0]        state, nxt_state, base;
    logic [CNT_W-1:0]  cnt, nxt_cnt;
    logic [1:0]        cl, cl_nxt;
    logic [2:0]        cmd, err_val;
    logic              err_set, row_we, wr_cmd, rd_issue, mem_we;
    logic [ADDR_W-1:0] row_q;
    logic [1:0]        ba_q;
    logic [2:0]        rd_v;
    logic [DQ_W-1:0]   rd_d [3];
    logic [DQ_W-1:0]   mem  [2**MEM_AW];
    logic [1:0]        sel;

    logic [ADDR_W+COL_W-1:0] full_idx;
    logic [MEM_AW-1:0]       mem_idx;
    logic                    unused_bits;

    assign full_idx    = {row_q, addr[COL_W-1:0]};
    assign mem_idx     = full_idx[MEM_AW-1:0];
    assign unused_bits = ^{ba_q, full_idx, addr};
    assign state_out   = state;
    // Output tap: stage k holds a READ issued k+1 edges before the output edge.
    assign sel         = (cl == 2'd3) ? 2'd2 : 2'd1;

    function automatic logic is_timed(input logic [3:0] s);
        return s inside {S_PRE, S_ROWNG, S_WREC, S_WRECA, S_AUTO, S_MRS};
    endfunction

    function automatic logic [3:0] after_state(input logic [3:0] s);
        case (s)
            S_ROWNG, S_WREC: return S_ROWA;
            S_WRECA:         return S_PRE;
            default:         return S_IDLE;
        endcase
    endfunction

    // Counter holds remaining cycles minus one, so a state loaded with T is
    // visible for exactly T cycles and releases on the edge where it reads 0.
    function automatic logic [CNT_W-1:0] load_cnt(input logic [3:0] s);
        case (s)
            S_ROWNG:         return CNT_W'(T_RCD - 1);
            S_PRE:           return CNT_W'(T_RP - 1);
            S_AUTO:          return CNT_W'(T_RC - 1);
            S_MRS:           return CNT_W'(T_MRD - 1);
            S_WREC, S_WRECA: return CNT_W'(T_WR - 1);
            default:         return '0;
        endcase
    endfunction

    always_comb begin
        cmd = C_NOP;
        if (!cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b011:  cmd = C_ACT;
                3'b101:  cmd = C_READ;
                3'b100:  cmd = C_WRITE;
                3'b010:  cmd = C_PRE;
                3'b001:  cmd = C_REF;
                3'b000:  cmd = C_MRS;
                default: cmd = C_NOP;   // NOP and BST
            endcase
        end
    end

    // NOTE: combinational logic uses blocking assignments and gives every
    // output a default first, so no latch can be inferred on any path.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        cl_nxt    = cl;
        err_set   = 1'b0;
        err_val   = err_code;
        row_we    = 1'b0;
        wr_cmd    = 1'b0;
        rd_issue  = 1'b0;
        base      = state;

        // On the release edge the command is judged against the state the
        // timer hands over to, so a READ exactly T_RCD after ACT is legal.
        if (is_timed(state)) begin
            if (cnt != '0) begin
                nxt_cnt = cnt - CNT_W'(1);
            end else begin
                base      = after_state(state);
                nxt_state = base;
                nxt_cnt   = load_cnt(base);
            end
        end

        if (is_timed(base)) begin
            if (cmd != C_NOP) begin
                err_set = 1'b1;
                err_val = 3'd2;
            end
        end else begin
            case (base)
                S_IDLE: begin
                    case (cmd)
                        C_NOP: ;
                        C_ACT: begin
                            nxt_state = S_ROWNG;
                            row_we    = 1'b1;
                        end
                        C_REF: nxt_state = S_AUTO;
                        C_PRE: nxt_state = S_PRE;
                        C_MRS: begin
                            if (addr[6:4] == 3'd2 || addr[6:4] == 3'd3) begin
                                nxt_state = S_MRS;
                                cl_nxt    = addr[5:4];
                            end else begin
                                err_set = 1'b1;
                                err_val = 3'd3;
                            end
                        end
                        default: begin
                            err_set = 1'b1;
                            err_val = 3'd1;
                        end
                    endcase
                end
                S_ROWA: begin
                    case (cmd)
                        C_NOP: ;
                        C_READ: begin
                            rd_issue = 1'b1;
                            if (addr[10]) nxt_state = S_PRE;
                        end
                        C_WRITE: begin
                            wr_cmd    = 1'b1;
                            nxt_state = addr[10] ? S_WRECA : S_WREC;
                        end
                        C_PRE: nxt_state = S_PRE;
                        default: begin
                            err_set = 1'b1;
                            err_val = 3'd1;
                        end
                    endcase
                end
                default: nxt_state = S_IDLE;
            endcase
            if (nxt_state != base) nxt_cnt = load_cnt(nxt_state);
        end
    end

    assign mem_we = wr_cmd && !dqm && !rst;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cl       <= 2'(CL_RESET);
            cmd_err  <= 1'b0;
            err_code <= 3'd0;
            row_q    <= '0;
            ba_q     <= '0;
            rd_v     <= '0;
            dq_oe    <= 1'b0;
            dq_out   <= '0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            cl      <= cl_nxt;
            cmd_err <= err_set;
            if (err_set) err_code <= err_val;
            if (row_we) begin
                row_q <= addr;
                ba_q  <= ba;
            end
            rd_v   <= {rd_v[1:0], rd_issue};
            dq_oe  <= rd_v[sel];
            dq_out <= rd_v[sel] ? rd_d[sel] : '0;
        end
    end

    // NOTE: the array and the read-data stages carry no reset; only the valid
    // bits are flushed, and array contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= dq_in;
        rd_d[0] <= mem[mem_idx];
        rd_d[1] <= rd_d[0];
        rd_d[2] <= rd_d[1];
    end

endmodule

// File: tb/tb_sdram_cmd_responder.sv
`timescale 1ns/1ps
module tb_sdram_cmd_responder;

    localparam int DQ_W = 16, ADDR_W = 12, COL_W = 8, MEM_AW = 8;
    localparam int T_RCD = 2, T_RP = 2, T_RC = 6, T_MRD = 2, T_WR = 2, CL_RESET = 2;

    typedef enum int {NOP, DESEL, BST, ACT, READ, WRITE, PRE, REF, MRS} cmd_t;

    logic              clk = 1'b0, rst = 1'b1;
    logic              cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0]        ba = 2'd0;
    logic [ADDR_W-1:0] addr = '0;
    logic              dqm = 1'b0;
    logic [DQ_W-1:0]   dq_in = '0;
    logic [DQ_W-1:0]   dq_out;
    logic              dq_oe;
    logic [3:0]        state_out;
    logic              cmd_err;
    logic [2:0]        err_code;

    sdram_cmd_responder #(
        .DQ_W(DQ_W), .ADDR_W(ADDR_W), .COL_W(COL_W), .MEM_AW(MEM_AW),
        .T_RCD(T_RCD), .T_RP(T_RP), .T_RC(T_RC), .T_MRD(T_MRD), .T_WR(T_WR),
        .CL_RESET(CL_RESET)
    ) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .ba(ba), .addr(addr), .dqm(dqm), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
        .state_out(state_out), .cmd_err(cmd_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Device activity is a timeline of segments {code, end edge}; the device is
    // busy while any segment is pending and otherwise sits in IDLE or ROWA.
    typedef struct {logic [3:0] code; int end_e;} seg_t;
    typedef struct {int at; logic [DQ_W-1:0] data; bit known;} rd_t;

    seg_t            segq[$];
    rd_t             rdq[$];
    int              e = 0;
    int              m_stable = 0;
    int              m_cl = CL_RESET;
    int              m_row = 0;
    logic [DQ_W-1:0] m_mem [2**MEM_AW];
    bit              m_wr  [2**MEM_AW];
    bit              model_ok = 1'b0;
    logic [3:0]      exp_state = 4'h0;
    logic            exp_oe = 1'b0, exp_err = 1'b0, exp_known = 1'b1;
    logic [DQ_W-1:0] exp_dq = '0;
    logic [2:0]      exp_code = 3'd0;

    function automatic cmd_t pins_cmd();
        if (cs_n) return DESEL;
        case ({ras_n, cas_n, we_n})
            3'b111: return NOP;
            3'b110: return BST;
            3'b011: return ACT;
            3'b101: return READ;
            3'b100: return WRITE;
            3'b010: return PRE;
            3'b001: return REF;
            default: return MRS;
        endcase
    endfunction

    task automatic flag(input int code);
        exp_err  = 1'b1;
        exp_code = 3'(code);
    endtask

    task automatic model_step();
        cmd_t c;
        int   idx, mode;
        e++;
        if (rst) begin
            segq.delete();
            rdq.delete();
            m_stable = 0; m_cl = CL_RESET;
            exp_state = 4'h0; exp_oe = 1'b0; exp_dq = '0; exp_known = 1'b1;
            exp_err = 1'b0; exp_code = 3'd0;
            model_ok = 1'b1;
            return;
        end
        exp_oe = 1'b0; exp_dq = '0; exp_known = 1'b1;
        foreach (rdq[i]) if (rdq[i].at == e - m_cl) begin
            exp_oe = 1'b1; exp_dq = rdq[i].data; exp_known = rdq[i].known;
        end
        while (rdq.size() > 0 && rdq[0].at < e - 3) void'(rdq.pop_front());
        while (segq.size() > 0 && segq[0].end_e <= e) void'(segq.pop_front());
        exp_err = 1'b0;
        c    = pins_cmd();
        idx  = ((m_row << COL_W) + int'(addr[COL_W-1:0])) % (2**MEM_AW);
        mode = int'(addr[6:4]);
        if (segq.size() > 0) begin
            if (!(c inside {NOP, DESEL, BST})) flag(2);
        end else if (m_stable == 0) begin
            case (c)
                NOP, DESEL, BST: ;
                ACT: begin m_row = int'(addr); m_stable = 1; segq.push_back('{4'h7, e + T_RCD}); end
                REF: segq.push_back('{4'hA, e + T_RC});
                PRE: segq.push_back('{4'h6, e + T_RP});
                MRS: if (mode == 2 || mode == 3) begin
                         m_cl = mode; segq.push_back('{4'hB, e + T_MRD});
                     end else flag(3);
                default: flag(1);
            endcase
        end else begin
            case (c)
                NOP, DESEL, BST: ;
                READ: begin
                    rdq.push_back('{e, m_mem[idx], m_wr[idx]});
                    if (addr[10]) begin m_stable = 0; segq.push_back('{4'h6, e + T_RP}); end
                end
                WRITE: begin
                    if (!dqm) begin m_mem[idx] = dq_in; m_wr[idx] = 1'b1; end
                    if (addr[10]) begin
                        m_stable = 0;
                        segq.push_back('{4'h9, e + T_WR});
                        segq.push_back('{4'h6, e + T_WR + T_RP});
                    end else segq.push_back('{4'h8, e + T_WR});
                end
                PRE: begin m_stable = 0; segq.push_back('{4'h6, e + T_RP}); end
                default: flag(1);
            endcase
        end
        exp_state = (segq.size() > 0) ? segq[0].code : 4'(m_stable);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: every cycle once the model has seen a reset.
    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            check("m_state", 32'(state_out), 32'(exp_state));
            check("m_dq_oe", 32'(dq_oe), 32'(exp_oe));
            if (!exp_oe) check("m_dq_out_quiet", 32'(dq_out), 32'h0);
            else if (exp_known) check("m_dq_out", 32'(dq_out), 32'(exp_dq));
            check("m_cmd_err", 32'(cmd_err), 32'(exp_err));
            check("m_err_code", 32'(err_code), 32'(exp_code));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic put(input cmd_t c, input logic [ADDR_W-1:0] a,
                       input logic [DQ_W-1:0] d, input logic m);
        addr = a; dq_in = d; dqm = m; ba = 2'($urandom_range(0, 3));
        case (c)
            DESEL:   {cs_n, ras_n, cas_n, we_n} = {1'b1, 3'($urandom_range(0, 7))};
            NOP:     {cs_n, ras_n, cas_n, we_n} = 4'b0111;
            BST:     {cs_n, ras_n, cas_n, we_n} = 4'b0110;
            ACT:     {cs_n, ras_n, cas_n, we_n} = 4'b0011;
            READ:    {cs_n, ras_n, cas_n, we_n} = 4'b0101;
            WRITE:   {cs_n, ras_n, cas_n, we_n} = 4'b0100;
            PRE:     {cs_n, ras_n, cas_n, we_n} = 4'b0010;
            REF:     {cs_n, ras_n, cas_n, we_n} = 4'b0001;
            default: {cs_n, ras_n, cas_n, we_n} = 4'b0000;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input cmd_t c, input logic [ADDR_W-1:0] a = '0,
                         input logic [DQ_W-1:0] d = '0, input logic m = 1'b0);
        put(c, a, d, m);
        tick();
        put(NOP, '0, '0, 1'b0);
    endtask

    function automatic logic [ADDR_W-1:0] rw(input logic [7:0] col, input logic a10);
        return {1'b0, a10, 2'b00, col};
    endfunction

    function automatic logic [ADDR_W-1:0] mode_addr(input logic [2:0] cl);
        return {5'b0, cl, 4'b0};
    endfunction

    task automatic expect_state(input string name, input logic [3:0] s);
        check(name, 32'(state_out), 32'(s));
    endtask

    initial begin
        put(NOP, '0, '0, 1'b0);
        rst = 1'b1;
        tick(); tick();
        check("rst_state", 32'(state_out), 32'h0);
        check("rst_dq_oe", 32'(dq_oe), 32'h0);
        check("rst_dq_out", 32'(dq_out), 32'h0);
        check("rst_cmd_err", 32'(cmd_err), 32'h0);
        check("rst_err_code", 32'(err_code), 32'h0);
        rst = 1'b0;

        // CL=2 read after write, state sequence 7,7,1,8,8,1
        issue(ACT, 12'h005);                 expect_state("act_s1", 4'h7);
        issue(NOP);                          expect_state("act_s2", 4'h7);
        issue(NOP);                          expect_state("rowa", 4'h1);
        issue(WRITE, rw(8'h12, 1'b0), 16'hBEEF); expect_state("wrec1", 4'h8);
        issue(NOP);                          expect_state("wrec2", 4'h8);
        issue(NOP);                          expect_state("wrec_done", 4'h1);
        issue(READ, rw(8'h12, 1'b0));        check("cl2_oe_r0", 32'(dq_oe), 32'h0);
        issue(NOP);                          check("cl2_oe_r1", 32'(dq_oe), 32'h0);
        issue(NOP);                          check("cl2_oe_r2", 32'(dq_oe), 32'h1);
                                             check("cl2_data", 32'(dq_out), 32'hBEEF);
        issue(NOP);                          check("cl2_oe_r3", 32'(dq_oe), 32'h0);

        // MRS CL=3 then read
        issue(PRE);                          expect_state("pre1", 4'h6);
        issue(NOP); issue(NOP);              expect_state("pre_idle", 4'h0);
        issue(MRS, mode_addr(3'd3));         expect_state("mrs", 4'hB);
        issue(NOP); issue(NOP);              expect_state("mrs_idle", 4'h0);
        issue(ACT, 12'h005); issue(NOP); issue(NOP);
        issue(READ, rw(8'h12, 1'b0)); issue(NOP);
        issue(NOP);                          check("cl3_oe_r2", 32'(dq_oe), 32'h0);
        issue(NOP);                          check("cl3_oe_r3", 32'(dq_oe), 32'h1);
                                             check("cl3_data", 32'(dq_out), 32'hBEEF);
        issue(PRE); issue(NOP); issue(NOP);

        // Illegal CL keeps CL=3
        issue(MRS, mode_addr(3'd5));         check("badcl_err", 32'(cmd_err), 32'h1);
                                             check("badcl_code", 32'(err_code), 32'h3);
                                             expect_state("badcl_state", 4'h0);
        issue(NOP);                          check("badcl_pulse", 32'(cmd_err), 32'h0);
                                             check("badcl_hold", 32'(err_code), 32'h3);
        issue(ACT, 12'h005); issue(NOP); issue(NOP);
        issue(READ, rw(8'h12, 1'b1));        expect_state("rda_pre", 4'h6);
        issue(NOP);
        issue(NOP);                          check("keepcl_oe_r2", 32'(dq_oe), 32'h0);
        issue(NOP);                          check("keepcl_oe_r3", 32'(dq_oe), 32'h1);

        // READ in IDLE, READ too soon after ACT
        issue(READ, rw(8'h12, 1'b0));        check("idle_rd_err", 32'(cmd_err), 32'h1);
                                             check("idle_rd_code", 32'(err_code), 32'h1);
                                             expect_state("idle_rd_state", 4'h0);
        issue(NOP); issue(NOP);
        issue(NOP);                          check("idle_rd_no_oe", 32'(dq_oe), 32'h0);
        issue(ACT, 12'h005);
        issue(READ, rw(8'h12, 1'b0));        check("early_rd_code", 32'(err_code), 32'h2);
                                             check("early_rd_err", 32'(cmd_err), 32'h1);
                                             expect_state("early_rd_state", 4'h7);
        issue(NOP);                          expect_state("early_rowa", 4'h1);

        // WRITE with auto-precharge
        issue(WRITE, rw(8'h20, 1'b1), 16'h1234); expect_state("wra1", 4'h9);
        issue(NOP);                          expect_state("wra2", 4'h9);
        issue(NOP);                          expect_state("wra_pre1", 4'h6);
        issue(NOP);                          expect_state("wra_pre2", 4'h6);
        issue(NOP);                          expect_state("wra_idle", 4'h0);
        issue(ACT, 12'h005);                 expect_state("wra_act", 4'h7);
                                             check("wra_act_ok", 32'(cmd_err), 32'h0);

        // Masked write leaves old data
        issue(NOP); issue(NOP);
        issue(WRITE, rw(8'h20, 1'b0), 16'hFFFF, 1'b1); expect_state("mask_wrec", 4'h8);
        issue(NOP); issue(NOP);
        issue(READ, rw(8'h20, 1'b1)); issue(NOP); issue(NOP);
        issue(NOP);                          check("mask_oe", 32'(dq_oe), 32'h1);
                                             check("mask_data", 32'(dq_out), 32'h1234);

        // Refresh runs full T_RC; REF in its third cycle is flagged
        issue(REF);                          expect_state("ref1", 4'hA);
        issue(NOP);                          expect_state("ref2", 4'hA);
        issue(REF);                          expect_state("ref3", 4'hA);
                                             check("ref_again_code", 32'(err_code), 32'h2);
                                             check("ref_again_err", 32'(cmd_err), 32'h1);
        issue(NOP); issue(NOP);
        issue(NOP);                          expect_state("ref6", 4'hA);
        issue(NOP);                          expect_state("ref_idle", 4'h0);

        // Reset right after a READ
        issue(ACT, 12'h005); issue(NOP); issue(NOP);
        issue(READ, rw(8'h12, 1'b0));
        rst = 1'b1;
        tick();
        rst = 1'b0;                          expect_state("rst_mid_state", 4'h0);
        for (int i = 0; i < 3; i++) begin
            issue(NOP);                      check("rst_mid_no_oe", 32'(dq_oe), 32'h0);
        end
        issue(ACT, 12'h005); issue(NOP); issue(NOP);
        issue(READ, rw(8'h12, 1'b0)); issue(NOP);
        issue(NOP);                          check("post_rst_oe", 32'(dq_oe), 32'h1);
                                             check("post_rst_data", 32'(dq_out), 32'hBEEF);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int   r;
            cmd_t c;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                rst = 1'b1;
                put(NOP, '0, '0, 1'b0);
                tick();
                rst = 1'b0;
            end else begin
                case ($urandom_range(0, 11))
                    0, 1, 2: c = NOP;
                    3:       c = DESEL;
                    4:       c = BST;
                    5:       c = ACT;
                    6, 7:    c = READ;
                    8, 9:    c = WRITE;
                    10:      c = ($urandom_range(0, 1) == 0) ? PRE : REF;
                    default: c = MRS;
                endcase
                case (c)
                    ACT:  put(c, 12'($urandom_range(0, 4095)), '0, 1'b0);
                    MRS:  put(c, mode_addr(3'($urandom_range(0, 7))), '0, 1'b0);
                    READ, WRITE:
                          put(c, rw(8'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0)),
                              16'($urandom), ($urandom_range(0, 7) == 0));
                    default: put(c, 12'($urandom_range(0, 4095)), 16'($urandom), 1'b0);
                endcase
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
